bcd_serial_addsub: RTL

BCD_SERIAL_ADDSUB -- requirements
Module: bcd_serial_addsub

---
 rtl/bcd_serial_addsub_pkg.sv | 10 +
 rtl/bcd_serial_addsub_digit.sv | 15 +
 rtl/bcd_serial_addsub.sv | 97 +++++++++
 3 files changed

// File: rtl/bcd_serial_addsub_pkg.sv
// bcd_serial_addsub_pkg: shared states, BCD constants, default width and the nines-complement helper
package bcd_serial_addsub_pkg;
  localparam int DEFAULT_DIGITS = 4;
  localparam logic [3:0] BCD_NINE = 4'd9;
  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ADD = 2'd1, S_FIX = 2'd2, S_DONE = 2'd3} state_t;
  function automatic logic [3:0] nines(input logic [3:0] d);
    return BCD_NINE - d;
  endfunction
endpackage

// File: rtl/bcd_serial_addsub_digit.sv
// bcd_digit_adder: one BCD digit x+y+ci -> s,co with +6 decimal correction
module bcd_digit_adder (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] bin;
  always_comb begin
    bin = {1'b0, x} + {1'b0, y} + {4'd0, ci};
    co = bin > 5'd9;
    s = co ? bin[3:0] + 4'd6 : bin[3:0];
  end
endmodule

// File: rtl/bcd_serial_addsub.sv
// bcd_serial_addsub: digit-serial BCD add/sub (start/sub/a/b in; busy/done/result/cout/neg/err out)
module bcd_serial_addsub
  import bcd_serial_addsub_pkg::*;
#(
  parameter int DIGITS = DEFAULT_DIGITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                sub,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] result,
  output logic                cout,
  output logic                neg,
  output logic                err
);
  localparam int W = 4 * DIGITS;
  localparam int IW = $clog2(DIGITS);
  state_t state;
  logic [W-1:0] ra, rb, acc;
  logic [IW-1:0] idx;
  logic carry, e, rsub;
  logic [3:0] ad, bd, pd, x, y, s;
  logic co, last, bad;
  always_comb begin
    ad = ra[4*idx +: 4];
    bd = rb[4*idx +: 4];
    pd = acc[4*idx +: 4];
    x = state == S_FIX ? pd : ad;
    y = state == S_FIX ? 4'd0 : rsub ? nines(bd) : bd;
    last = idx == IW'(DIGITS - 1);
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      bad = bad | (ra[4*i +: 4] > BCD_MAX_DIGIT) | (rb[4*i +: 4] > BCD_MAX_DIGIT);
  end
  bcd_digit_adder u_add (.x(x), .y(y), .ci(carry), .s(s), .co(co));
  // done is registered and lands in IDLE, so busy also covers the done cycle
  assign busy = (state != S_IDLE) | done;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      idx <= '0;
      carry <= 1'b0;
      e <= 1'b0;
      rsub <= 1'b0;
      ra <= '0;
      rb <= '0;
      acc <= '0;
      done <= 1'b0;
      result <= '0;
      cout <= 1'b0;
      neg <= 1'b0;
      err <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          ra <= a;
          rb <= b;
          rsub <= sub;
          idx <= '0;
          carry <= 1'b0;
          acc <= '0;
          state <= S_ADD;
        end
        S_ADD: begin
          acc[4*idx +: 4] <= s;
          carry <= co;
          idx <= last ? '0 : idx + 1'b1;
          if (last) begin
            e <= co;
            state <= rsub ? S_FIX : S_DONE;
          end
        end
        S_FIX: begin
          // E=1: carry already holds the end-around 1; E=0: complement the partial sum
          acc[4*idx +: 4] <= e ? s : nines(pd);
          carry <= co;
          idx <= last ? '0 : idx + 1'b1;
          if (last) state <= S_DONE;
        end
        S_DONE: begin
          done <= 1'b1;
          result <= bad ? '0 : acc;
          cout <= !bad && !rsub && carry;
          neg <= !bad && rsub && !e && acc != '0;
          err <= bad;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
